arc4_seq: RTL and testbench
===========================

ARC4_SEQ -- requirements
Module: arc4_seq

Interface
REQ-001 Parameter: TIMEOUT, default 1024, max cycles any sub-block may stay busy (legal range 2..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  start request; sampled on posedge only while rdy=1.
REQ-005 rdy  output  1  high when idle and able to accept en.
REQ-006 done  output  1  one-cycle pulse on successful completion of all three stages.
REQ-007 err  output  1  sticky timeout flag; cleared when next en is accepted.
REQ-008 stage  output  2  current memory owner: 0 none, 1 init, 2 ksa, 3 prga.
REQ-009 init_en, ksa_en, prga_en  output  1 each  start pulses to the sub-blocks.
REQ-010 init_rdy, ksa_rdy, prga_rdy  input  1 each  sub-block ready.
REQ-011 init_addr/ksa_addr/prga_addr  input  8 each; init_wrdata/ksa_wrdata/prga_wrdata  input  8 each; init_wren/ksa_wren/prga_wren  input  1 each  sub-block S-memory requests.
REQ-012 s_addr  output  8; s_wrdata  output  8; s_wren  output  1  single S-memory port.

Function
REQ-013 States: IDLE, INIT_GO, INIT_BUSY, KSA_GO, KSA_BUSY, PRGA_GO, PRGA_BUSY.
REQ-014 IDLE: rdy=1; en=1 at posedge -> INIT_GO, err cleared, rdy=0 from next cycle; en=0 -> stay.
REQ-015 en while not IDLE is ignored; no queuing.
REQ-016 X_GO: x_en asserted combinationally only when x_rdy=1; same posedge -> X_BUSY; x_rdy=0 -> stay in X_GO, x_en=0 (GO cycles are not timed).
REQ-017 x_en high for exactly one cycle per stage; at most one sub-block en high in any cycle.
REQ-018 X_BUSY: x_rdy=1 at posedge -> next stage GO (INIT->KSA_GO, KSA->PRGA_GO, PRGA->IDLE with done=1 in the first IDLE cycle).
REQ-019 First BUSY cycle x_rdy is expected low (sub-block drops rdy the edge after sampling en); if high anyway it is treated as completion.
REQ-020 16-bit busy counter cleared on entry to each BUSY state, +1 per BUSY cycle.
REQ-021 Counter reaching TIMEOUT with x_rdy=0 -> IDLE, err=1, done=0; x_rdy=1 on that same edge wins (completion, not timeout).
REQ-022 stage: 1 in INIT_GO/INIT_BUSY, 2 in KSA_*, 3 in PRGA_*, 0 in IDLE.
REQ-023 Port mux: s_addr/s_wrdata/s_wren = owner's inputs per stage, purely combinational (zero latency).
REQ-024 stage=0: s_addr=0, s_wrdata=0, s_wren=0; non-owner wren ignored.
REQ-025 Sub-block read data is fanned out externally; this block does not touch read data.

Reset
REQ-026 rst_n=0 at any time, including mid-stage: immediately IDLE, rdy=1, done=0, err=0, stage=0, all x_en=0, s_wren=0, s_addr=0, s_wrdata=0, counter=0.
REQ-027 Release of rst_n: first en accepted on first posedge with rst_n=1.

Verification
REQ-028 Nominal: stubs busy 256/256/512 cycles, pulse en -> init_en, ksa_en, prga_en each exactly one cycle in order; done pulse once; rdy returns 1; err=0.
REQ-029 Mux: during INIT_BUSY drive init_addr=0x2A, wren=1 and ksa_wren=1 -> s_addr=0x2A, s_wren from init only; in IDLE s_wren=0, s_addr=0.
REQ-030 Late sub-block rdy: ksa_rdy held 0 for 5 cycles entering KSA_GO -> ksa_en stays 0, asserts on first cycle ksa_rdy=1.
REQ-031 Timeout: TIMEOUT=16, ksa stub never finishes -> after 16 KSA_BUSY cycles IDLE, err=1, done=0, prga_en never asserted; next en clears err.
REQ-032 Reset mid-PRGA: rst_n low 2 cycles -> all outputs at reset values immediately, stage=0; after release fresh en restarts at init_en.
REQ-033 en pulses during INIT_BUSY -> no effect on sequence or counts.

Source files
------------

// File: rtl/arc4_seq.sv
// ARC4 top-level sequencer: runs init, ksa and prga sub-blocks in turn, with a
// per-stage busy timeout, and muxes the single S-memory port to the active owner.
module arc4_seq #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic       done,
    output logic       err,
    output logic [1:0] stage,
    output logic       init_en,
    output logic       ksa_en,
    output logic       prga_en,
    input  logic       init_rdy,
    input  logic       ksa_rdy,
    input  logic       prga_rdy,
    input  logic [7:0] init_addr,
    input  logic [7:0] ksa_addr,
    input  logic [7:0] prga_addr,
    input  logic [7:0] init_wrdata,
    input  logic [7:0] ksa_wrdata,
    input  logic [7:0] prga_wrdata,
    input  logic       init_wren,
    input  logic       ksa_wren,
    input  logic       prga_wren,
    output logic [7:0] s_addr,
    output logic [7:0] s_wrdata,
    output logic       s_wren
);

    typedef enum logic [2:0] {
        IDLE,
        INIT_GO,
        INIT_BUSY,
        KSA_GO,
        KSA_BUSY,
        PRGA_GO,
        PRGA_BUSY
    } state_t;

    // Counter holds (cycles spent in BUSY - 1), so the last allowed cycle is TIMEOUT-1.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] busy_cnt;
    logic        done_q;
    logic        err_q;
    logic        cnt_expired;

    assign cnt_expired = (busy_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy_cnt <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= INIT_GO;
                        err_q <= 1'b0;
                    end
                end
                INIT_GO: begin
                    if (init_rdy) begin
                        state    <= INIT_BUSY;
                        busy_cnt <= '0;
                    end
                end
                INIT_BUSY: begin
                    if (init_rdy) begin
                        state <= KSA_GO;
                    end else if (cnt_expired) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + 16'd1;
                    end
                end
                KSA_GO: begin
                    if (ksa_rdy) begin
                        state    <= KSA_BUSY;
                        busy_cnt <= '0;
                    end
                end
                KSA_BUSY: begin
                    if (ksa_rdy) begin
                        state <= PRGA_GO;
                    end else if (cnt_expired) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + 16'd1;
                    end
                end
                PRGA_GO: begin
                    if (prga_rdy) begin
                        state    <= PRGA_BUSY;
                        busy_cnt <= '0;
                    end
                end
                PRGA_BUSY: begin
                    if (prga_rdy) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else if (cnt_expired) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rdy  = (state == IDLE);
    assign done = done_q;
    assign err  = err_q;

    // Start pulses are gated by the sub-block's ready so a late sub-block simply stalls GO.
    assign init_en = (state == INIT_GO) && init_rdy;
    assign ksa_en  = (state == KSA_GO)  && ksa_rdy;
    assign prga_en = (state == PRGA_GO) && prga_rdy;

    always_comb begin
        stage = 2'd0;
        case (state)
            INIT_GO, INIT_BUSY: stage = 2'd1;
            KSA_GO,  KSA_BUSY:  stage = 2'd2;
            PRGA_GO, PRGA_BUSY: stage = 2'd3;
            default:            stage = 2'd0;
        endcase
    end

    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (stage)
            2'd1: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            2'd2: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            2'd3: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: begin
                s_addr   = '0;
                s_wrdata = '0;
                s_wren   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arc4_seq.sv
// Bench for arc4_seq: scoreboard of start/done events on a default-TIMEOUT instance,
// plus a TIMEOUT=16 instance for the completion-vs-timeout boundary.
module tb_arc4_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       en, rdy, done, err;
    logic [1:0] stage;
    logic       init_en, ksa_en, prga_en;
    logic       init_rdy, ksa_rdy, prga_rdy;
    logic [7:0] init_addr, ksa_addr, prga_addr;
    logic [7:0] init_wrdata, ksa_wrdata, prga_wrdata;
    logic       init_wren, ksa_wren, prga_wren;
    logic [7:0] s_addr, s_wrdata;
    logic       s_wren;

    logic       t_en, t_rdy, t_done, t_err;
    logic [1:0] t_stage;
    logic       t_init_en, t_ksa_en, t_prga_en;
    logic       t_init_rdy, t_ksa_rdy, t_prga_rdy;
    logic [7:0] t_s_addr, t_s_wrdata;
    logic       t_s_wren;

    arc4_seq dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .done(done), .err(err), .stage(stage),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
        .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    arc4_seq #(.TIMEOUT(16)) dut_t (
        .clk(clk), .rst_n(rst_n), .en(t_en), .rdy(t_rdy), .done(t_done), .err(t_err), .stage(t_stage),
        .init_en(t_init_en), .ksa_en(t_ksa_en), .prga_en(t_prga_en),
        .init_rdy(t_init_rdy), .ksa_rdy(t_ksa_rdy), .prga_rdy(t_prga_rdy),
        .init_addr(8'h00), .ksa_addr(8'h00), .prga_addr(8'h00),
        .init_wrdata(8'h00), .ksa_wrdata(8'h00), .prga_wrdata(8'h00),
        .init_wren(1'b0), .ksa_wren(1'b0), .prga_wren(1'b0),
        .s_addr(t_s_addr), .s_wrdata(t_s_wrdata), .s_wren(t_s_wren)
    );

    // Sub-block stubs: 0..2 serve dut, 3..5 serve dut_t. A stub drops rdy on the edge
    // after it samples en and stays low for len cycles; hold forces rdy low.
    int          len[6];
    logic [15:0] rem[6];
    logic        hold[6];
    logic [5:0]  en_v, rdy_v;

    assign en_v = {t_prga_en, t_ksa_en, t_init_en, prga_en, ksa_en, init_en};
    always_comb begin
        rdy_v = '0;
        for (int i = 0; i < 6; i++) rdy_v[i] = (rem[i] == 16'd0) && !hold[i];
    end
    assign init_rdy   = rdy_v[0];
    assign ksa_rdy    = rdy_v[1];
    assign prga_rdy   = rdy_v[2];
    assign t_init_rdy = rdy_v[3];
    assign t_ksa_rdy  = rdy_v[4];
    assign t_prga_rdy = rdy_v[5];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) rem[i] <= 16'd0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (en_v[i])             rem[i] <= 16'(len[i]);
                else if (rem[i] != 16'd0) rem[i] <= rem[i] - 16'd1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] ev;     // {done, prga_en, ksa_en, init_en}
        logic [1:0] stage;
    } exp_t;
    exp_t q[$];

    always @(negedge clk) begin
        logic [3:0] ev;
        exp_t       e;
        ev = {done, prga_en, ksa_en, init_en};
        if (rst_n && ev != 4'd0) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected actual ev=%b stage=%0d required none", ev, stage);
            end else begin
                e = q.pop_front();
                if (ev !== e.ev || stage !== e.stage) begin
                    n_bad++;
                    $display("FAIL sb_event actual ev=%b stage=%0d required ev=%b stage=%0d",
                             ev, stage, e.ev, e.stage);
                end
            end
        end
    end

    int t_ni, t_nk, t_np, t_nd, t_kb;
    always @(negedge clk) begin
        if (rst_n) begin
            if (t_init_en) t_ni++;
            if (t_ksa_en)  t_nk++;
            if (t_prga_en) t_np++;
            if (t_done)    t_nd++;
            if (t_stage == 2'd2 && !t_ksa_en) t_kb++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input bit with_done);
        q.push_back(exp_t'{4'b0001, 2'd1});
        q.push_back(exp_t'{4'b0010, 2'd2});
        q.push_back(exp_t'{4'b0100, 2'd3});
        if (with_done) q.push_back(exp_t'{4'b1000, 2'd0});
    endtask

    task automatic pulse_en();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    // Waits for a cycle in stage s with no start pulse (BUSY, or a stalled GO).
    task automatic wait_quiet_stage(input logic [1:0] s, input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (stage == s && !(init_en || ksa_en || prga_en)) return;
            tick();
        end
        chk(tag, 32'(stage), 32'(s));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 5000 && q.size() != 0; i++) tick();
        tick();
        chk(tag, q.size(), 0);
    endtask

    task automatic t_clear();
        t_ni = 0; t_nk = 0; t_np = 0; t_nd = 0; t_kb = 0;
    endtask

    task automatic t_run(input string tag);
        t_en = 1'b1;
        tick();
        t_en = 1'b0;
        for (int i = 0; i < 500 && !t_rdy; i++) tick();
        tick();
        chk({tag, "_rdy"}, t_rdy, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; t_en = 1'b0;
        init_addr = '0; ksa_addr = '0; prga_addr = '0;
        init_wrdata = '0; ksa_wrdata = '0; prga_wrdata = '0;
        init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
        len = '{256, 256, 512, 3, 15, 3};
        for (int i = 0; i < 6; i++) hold[i] = 1'b0;
        t_clear();
        repeat (2) @(posedge clk);
        #1;

        chk("rst_rdy",   rdy, 1);
        chk("rst_done",  done, 0);
        chk("rst_err",   err, 0);
        chk("rst_stage", stage, 0);
        chk("rst_ens",   {init_en, ksa_en, prga_en}, 0);
        chk("rst_s_port", {s_wren, s_addr, s_wrdata}, 0);
        rst_n = 1'b1;

        // Nominal run with mux checks and ignored en during INIT_BUSY.
        push_run(1'b1);
        pulse_en();
        chk("nom_rdy_low", rdy, 0);
        wait_quiet_stage(2'd1, "nom_wait_init_busy");
        init_addr = 8'h2A; init_wrdata = 8'hC3; init_wren = 1'b1;
        ksa_addr = 8'h77; ksa_wrdata = 8'h11; ksa_wren = 1'b1;
        #1;
        chk("mux_init_addr", s_addr, 8'h2A);
        chk("mux_init_data", s_wrdata, 8'hC3);
        chk("mux_init_wren", s_wren, 1);
        init_wren = 1'b0;
        #1;
        chk("mux_nonowner_wren", s_wren, 0);
        en = 1'b1;
        repeat (3) tick();
        en = 1'b0;
        chk("busy_en_ignored_rdy", rdy, 0);
        chk("busy_en_ignored_stage", stage, 1);
        drain("nom_drain");
        chk("nom_rdy", rdy, 1);
        chk("nom_err", err, 0);
        chk("idle_s_wren", s_wren, 0);
        chk("idle_s_addr", s_addr, 0);
        chk("idle_s_data", s_wrdata, 0);
        ksa_wren = 1'b0; init_addr = '0; ksa_addr = '0;

        // Late ksa_rdy: start pulse waits in KSA_GO.
        len[0] = 4; len[1] = 4; len[2] = 4;
        hold[1] = 1'b1;
        push_run(1'b1);
        pulse_en();
        wait_quiet_stage(2'd2, "late_wait_ksa_go");
        for (int k = 0; k < 5; k++) begin
            chk("late_ksa_en_low", ksa_en, 0);
            tick();
        end
        hold[1] = 1'b0;
        #1;
        chk("late_ksa_en_high", ksa_en, 1);
        drain("late_drain");

        // Reset in the middle of PRGA, then immediate restart.
        push_run(1'b0);
        pulse_en();
        wait_quiet_stage(2'd3, "rstmid_wait_prga");
        prga_addr = 8'h99; prga_wrdata = 8'h5E; prga_wren = 1'b1;
        #1;
        chk("mux_prga_addr", s_addr, 8'h99);
        chk("mux_prga_wren", s_wren, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_stage", stage, 0);
        chk("rstmid_rdy_done_err", {rdy, done, err}, 3'b100);
        chk("rstmid_ens", {init_en, ksa_en, prga_en}, 0);
        chk("rstmid_s_port", {s_wren, s_addr, s_wrdata}, 0);
        chk("rstmid_q_empty", q.size(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        push_run(1'b1);
        @(posedge clk);
        #1;
        en = 1'b0;
        chk("restart_first_edge", stage, 1);
        prga_wren = 1'b0; prga_addr = '0;
        drain("restart_drain");

        // TIMEOUT=16: ready on the 16th busy edge completes.
        t_clear();
        t_run("bnd");
        chk("bnd_ksa_busy_cycles", t_kb, 16);
        chk("bnd_done", t_nd, 1);
        chk("bnd_prga_en", t_np, 1);
        chk("bnd_err", t_err, 0);

        // One cycle slower times out.
        len[4] = 16;
        t_clear();
        t_run("tmo");
        chk("tmo_ksa_busy_cycles", t_kb, 16);
        chk("tmo_done", t_nd, 0);
        chk("tmo_prga_en", t_np, 0);
        chk("tmo_err", t_err, 1);
        chk("tmo_stage", t_stage, 0);

        // Next accepted en clears err.
        len[4] = 3;
        t_clear();
        t_en = 1'b1;
        tick();
        t_en = 1'b0;
        chk("clr_err", t_err, 0);
        chk("clr_stage", t_stage, 1);
        for (int i = 0; i < 500 && !t_rdy; i++) tick();
        tick();
        chk("clr_done", t_nd, 1);
        chk("clr_starts", {t_ni[3:0], t_nk[3:0], t_np[3:0]}, 12'h111);

        chk("sb_final_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
